mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: one bus access at a time through an IDLE/REQ/DONE handshake.
// Define MEM_TIMEOUT_EN to abort a REQ that waits TIMEOUT_CYCLES cycles for bus_ack.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        mem_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t     state, state_nxt;
   logic       is_word_op, legal, start, req_err, timeout;
   logic       load_q, byte_q;
   logic [1:0] lane_q;

   always_comb begin
      is_word_op = (op == 6'd11) || (op == 6'd13) || (op == 6'd14);
      legal      = 1'b0;
      if (mem_read && !mem_write)
         legal = (op == 6'd10) || (op == 6'd11);
      else if (mem_write && !mem_read)
         legal = (op == 6'd12) || (op == 6'd13) || (op == 6'd14);
      // A misaligned word access is rejected before it ever reaches the bus.
      start   = (state == IDLE) && legal && (!is_word_op || addr[1:0] == 2'b00);
      req_err = (state == IDLE) && (mem_read || mem_write) && !start;
   end

`ifdef MEM_TIMEOUT_EN
   localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (state == REQ)
         tmo_cnt <= tmo_cnt + 1'b1;
      else
         tmo_cnt <= '0;
   end

   assign timeout = (state == REQ) && (tmo_cnt == LAST) && !bus_ack;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bus_req   = 1'b0;
      case (state)
         IDLE: begin
            stall = start;
            if (start) state_nxt = REQ;
         end
         REQ: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            if (bus_ack || timeout) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_be      <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         mem_err     <= 1'b0;
         load_q      <= 1'b0;
         byte_q      <= 1'b0;
         lane_q      <= '0;
      end else begin
         rdata_valid <= 1'b0;
         mem_err     <= 1'b0;
         if (state == IDLE) begin
            mem_err <= req_err;
            if (start) begin
               bus_addr  <= {addr[31:2], 2'b00};
               bus_we    <= mem_write;
               load_q    <= mem_read;
               byte_q    <= !is_word_op;
               lane_q    <= addr[1:0];
               bus_be    <= is_word_op ? 4'b1111 : (4'b0001 << addr[1:0]);
               bus_wdata <= is_word_op ? wdata : {4{wdata[7:0]}};
            end
         end else if (state == REQ) begin
            if (bus_ack) begin
               rdata_valid <= load_q;
               if (load_q)
                  rdata <= byte_q ? {24'h0, bus_rdata[{lane_q, 3'b000} +: 8]} : bus_rdata;
            end else if (timeout) begin
               mem_err <= 1'b1;
            end
         end
      end
   end

endmodule
